lmsm_hazard_sequencer: RTL and testbench
========================================

# lmsm_hazard_sequencer

Pipeline control block between decode (ID) and register-read (RR) that sequences the 8-register datapath around the forwarding control unit. It detects the one case forwarding cannot cover, a load in RR/EX feeding the instruction in ID/RR, and inserts exactly one bubble. It also expands LM/SM instructions into one register micro-op per cycle, holding fetch/decode until the last micro-op issues. A branch flush from EX aborts any sequence in progress.

## Interface
Parameters:
- NUM_REGS, 8, architectural register count; LM/SM mask width
- ADDR_W, 3, register address width (log2 NUM_REGS)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID/RR holds a valid instruction
- id_is_lm / id_is_sm  in  1 each  instruction is load-multiple / store-multiple
- id_mask  in  NUM_REGS  LM/SM register mask; bit i selects Ri
- id_rs1_addr / id_rs2_addr  in  ADDR_W each  source addresses of ID/RR instruction
- id_uses_rs1 / id_uses_rs2  in  1 each  source actually read
- rr_ex_is_load  in  1  RR/EX holds a LW/LM micro-op
- rr_ex_rd_addr  in  ADDR_W  destination of RR/EX instruction
- rr_ex_reg_wr_en  in  1  RR/EX instruction writes the register file
- flush_in  in  1  branch/jump mispredict resolved in EX; kill younger work
- stall_if_id  out  1  hold PC and IF/ID, ID/RR registers
- bubble_rr_ex  out  1  load NOP into RR/EX this cycle
- multi_valid  out  1  micro-op presented to RR/EX this cycle
- multi_reg_addr  out  ADDR_W  register of current micro-op
- multi_offset  out  ADDR_W+1  word offset from base address (0,1,2…)
- multi_first / multi_last  out  1 each  first / last micro-op of sequence
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, MULTI.
- Load-use hazard (combinational, IDLE only): id_valid & rr_ex_is_load & rr_ex_reg_wr_en & ((id_uses_rs1 & id_rs1_addr==rr_ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==rr_ex_rd_addr)). The hazard raises stall_if_id=1 and bubble_rr_ex=1. Next cycle the load has advanced, so at most one bubble is inserted per load.
- LM/SM start: in IDLE, when id_valid & (id_is_lm|id_is_sm) & no load-use hazard & !flush_in:
  - Latch id_mask into mask_q.
  - Clear the offset counter.
  - Go to MULTI if mask nonzero.
  - Mask==0: no micro-ops; bubble_rr_ex=1 for one cycle; stay IDLE.
- MULTI, each cycle:
  - multi_valid=1; multi_reg_addr = lowest set bit of mask_q; multi_offset = counter.
  - That bit is cleared and the counter increments.
  - multi_first=1 when counter==0. multi_last=1 when exactly one bit remains.
  - stall_if_id=1 in every MULTI cycle except the multi_last cycle.
  - After multi_last, return to IDLE.
- Load-use detection is suppressed in MULTI. The sequencer owns RR/EX.
- flush_in (any state), same cycle: multi_valid=0, stall_if_id=0, bubble_rr_ex=0. Next edge: state=IDLE, mask_q=0, counter=0.
- flush_in and a start in the same cycle: flush wins, no start.

## Timing
- Reset values: state IDLE, mask_q 0, counter 0, every output 0.
- Load-use: 1-cycle penalty, decided combinationally in the same cycle.
- LM/SM with N set bits (N≥1): first micro-op issues the cycle after start. The block issues N micro-ops on N consecutive cycles, and the ID/RR instruction stalls N cycles in total (start cycle plus N−1).
- Start cycle: stall_if_id=1, bubble_rr_ex=1, multi_valid=0.
- Full mask 8'hFF: offsets 0..7, multi_last at offset 7, counter never wraps.
- rst mid-sequence: next edge returns to IDLE with all outputs 0; the partial sequence is discarded.

## Configuration
- LMSM_SEQ_EN defined: LM/SM expansion as above.
- LMSM_SEQ_EN undefined:
  - No MULTI state; id_is_lm/id_is_sm/id_mask ignored.
  - multi_* outputs are tied 0; busy is tied 0.
  - Load-use stall logic is unchanged.

## Structure
- Shared pipeline package holds:
  - FSM state enum (IDLE, MULTI)
  - NUM_REGS / ADDR_W constants
  - NOP encoding used for bubbles
- One sub-module, lowest_set_bit_enc: NUM_REGS-bit mask in; index and nonzero flag out; purely combinational.

## Test plan
- Load R3 in RR/EX, ADD R1,R3,R2 in ID (uses rs1) -> stall_if_id=1 and bubble_rr_ex=1 for exactly 1 cycle, then 0.
- Load R3 in RR/EX, consumer reads R3 with id_uses_rs1=0 and id_uses_rs2=0 -> no stall.
- LM, mask 8'b1010_0101 -> micro-ops R0,R2,R5,R7 with offsets 0,1,2,3; first on R0, last on R7; stall_if_id high 4 cycles total.
- SM, mask 8'h00 -> one bubble, no multi_valid, busy stays 0.
- LM, mask 8'hFF, flush_in asserted on the 3rd micro-op -> that cycle multi_valid=0; next cycle IDLE with all outputs 0.
- rst asserted mid-LM with mask 8'hF0 -> after the edge, busy=0 and mask_q=0; a new LM with mask 8'h01 then issues a single R0 micro-op with first=last=1.

Source files
------------

// File: rtl/lmsm_hazard_sequencer_pkg.sv
// Shared pipeline definitions for the ID/RR hazard and LM/SM sequencer.
// Holds the register-file geometry, the sequencer state encoding and the bubble NOP.
package lmsm_hazard_sequencer_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;

  // Instruction word loaded into RR/EX when a bubble is inserted.
  localparam logic [15:0] NOP_INSTR = 16'hB000;

  typedef enum logic {
    IDLE  = 1'b0,
    MULTI = 1'b1
  } seq_state_t;

endpackage

// File: rtl/lmsm_hazard_sequencer_lowest_set_bit_enc.sv
// Priority encoder returning the index of the lowest set bit of a register mask.
// Purely combinational; index is 0 when the mask is empty.
module lowest_set_bit_enc
  import lmsm_hazard_sequencer_pkg::*;
#(
  parameter int NUM_REGS = lmsm_hazard_sequencer_pkg::NUM_REGS,
  parameter int ADDR_W   = lmsm_hazard_sequencer_pkg::ADDR_W
) (
  input  logic [NUM_REGS-1:0] mask,
  output logic [ADDR_W-1:0]   index,
  output logic                nonzero
);

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    index   = '0;
    nonzero = |mask;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i]) index = i[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/lmsm_hazard_sequencer.sv
// ID/RR load-use bubble insertion and LM/SM micro-op expansion.
// LM/SM expansion is built only when LMSM_SEQ_EN is defined; otherwise only the load-use stall exists.
module lmsm_hazard_sequencer
  import lmsm_hazard_sequencer_pkg::*;
#(
  parameter int NUM_REGS = lmsm_hazard_sequencer_pkg::NUM_REGS,
  parameter int ADDR_W   = lmsm_hazard_sequencer_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic                id_is_lm,
  input  logic                id_is_sm,
  input  logic [NUM_REGS-1:0] id_mask,
  input  logic [ADDR_W-1:0]   id_rs1_addr,
  input  logic [ADDR_W-1:0]   id_rs2_addr,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic                rr_ex_is_load,
  input  logic [ADDR_W-1:0]   rr_ex_rd_addr,
  input  logic                rr_ex_reg_wr_en,
  input  logic                flush_in,
  output logic                stall_if_id,
  output logic                bubble_rr_ex,
  output logic                multi_valid,
  output logic [ADDR_W-1:0]   multi_reg_addr,
  output logic [ADDR_W:0]     multi_offset,
  output logic                multi_first,
  output logic                multi_last,
  output logic                busy
);

  // A load's result is not forwardable to the instruction directly behind it.
  logic load_use;
  assign load_use = id_valid & rr_ex_is_load & rr_ex_reg_wr_en &
                    ((id_uses_rs1 & (id_rs1_addr == rr_ex_rd_addr)) |
                     (id_uses_rs2 & (id_rs2_addr == rr_ex_rd_addr)));

`ifdef LMSM_SEQ_EN

  localparam logic [ADDR_W:0]     CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [NUM_REGS-1:0] BIT0    = NUM_REGS'(1);

  seq_state_t          state_q, state_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   cur_idx;
  logic                cur_nz;
  logic [NUM_REGS-1:0] remaining;

  lowest_set_bit_enc #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_enc (
    .mask   (mask_q),
    .index  (cur_idx),
    .nonzero(cur_nz)
  );

  assign remaining = mask_q & ~(BIT0 << cur_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    count_d        = count_q;
    stall_if_id    = 1'b0;
    bubble_rr_ex   = 1'b0;
    multi_valid    = 1'b0;
    multi_reg_addr = '0;
    multi_offset   = '0;
    multi_first    = 1'b0;
    multi_last     = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_use) begin
          stall_if_id  = 1'b1;
          bubble_rr_ex = 1'b1;
        end else if (id_valid && (id_is_lm || id_is_sm)) begin
          // An empty mask retires as a single bubble without holding ID.
          bubble_rr_ex = 1'b1;
          stall_if_id  = |id_mask;
          mask_d       = id_mask;
          count_d      = '0;
          if (|id_mask) state_d = MULTI;
        end
      end
      MULTI: begin
        multi_valid    = cur_nz;
        multi_reg_addr = cur_idx;
        multi_offset   = count_q;
        multi_first    = (count_q == '0);
        multi_last     = (remaining == '0);
        stall_if_id    = (remaining != '0);
        mask_d         = remaining;
        count_d        = count_q + CNT_ONE;
        if (remaining == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A mispredict kills everything younger, including a sequence in flight.
    if (flush_in) begin
      stall_if_id    = 1'b0;
      bubble_rr_ex   = 1'b0;
      multi_valid    = 1'b0;
      multi_reg_addr = '0;
      multi_offset   = '0;
      multi_first    = 1'b0;
      multi_last     = 1'b0;
      state_d        = IDLE;
      mask_d         = '0;
      count_d        = '0;
    end
  end

  assign busy = (state_q == MULTI);

`else

  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, id_is_lm, id_is_sm, id_mask};

  assign stall_if_id    = load_use & ~flush_in;
  assign bubble_rr_ex   = load_use & ~flush_in;
  assign multi_valid    = 1'b0;
  assign multi_reg_addr = '0;
  assign multi_offset   = '0;
  assign multi_first    = 1'b0;
  assign multi_last     = 1'b0;
  assign busy           = 1'b0;

`endif

endmodule

// File: tb/tb_lmsm_hazard_sequencer.sv
// Scoreboard bench for lmsm_hazard_sequencer: a reference model pushes expected outputs per
// driven cycle and a negedge checker pops and compares them.
module tb_lmsm_hazard_sequencer;

  localparam int NR = 8;
  localparam int AW = 3;

  typedef struct packed {
    logic          rst;
    logic          id_valid;
    logic          is_lm;
    logic          is_sm;
    logic [NR-1:0] mask;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic          u1;
    logic          u2;
    logic          rr_load;
    logic          rr_wr;
    logic [AW-1:0] rd;
    logic          flush;
  } stim_t;

  typedef struct packed {
    logic          stall;
    logic          bubble;
    logic          mv;
    logic [AW-1:0] addr;
    logic [AW:0]   off;
    logic          first;
    logic          last;
    logic          busy;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_is_lm, id_is_sm;
  logic [NR-1:0] id_mask;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr;
  logic          id_uses_rs1, id_uses_rs2;
  logic          rr_ex_is_load;
  logic [AW-1:0] rr_ex_rd_addr;
  logic          rr_ex_reg_wr_en;
  logic          flush_in;
  logic          stall_if_id, bubble_rr_ex, multi_valid;
  logic [AW-1:0] multi_reg_addr;
  logic [AW:0]   multi_offset;
  logic          multi_first, multi_last, busy;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  // Reference model state
  logic          m_busy = 1'b0;
  logic [NR-1:0] m_mask = '0;
  logic [AW:0]   m_count = '0;

  always #5 clk = ~clk;

  lmsm_hazard_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_is_lm       (id_is_lm),
    .id_is_sm       (id_is_sm),
    .id_mask        (id_mask),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .rr_ex_is_load  (rr_ex_is_load),
    .rr_ex_rd_addr  (rr_ex_rd_addr),
    .rr_ex_reg_wr_en(rr_ex_reg_wr_en),
    .flush_in       (flush_in),
    .stall_if_id    (stall_if_id),
    .bubble_rr_ex   (bubble_rr_ex),
    .multi_valid    (multi_valid),
    .multi_reg_addr (multi_reg_addr),
    .multi_offset   (multi_offset),
    .multi_first    (multi_first),
    .multi_last     (multi_last),
    .busy           (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, expv, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t multi(input logic sm, input logic [NR-1:0] mask);
    stim_t s = '0;
    s.id_valid = 1'b1;
    s.is_lm = ~sm;
    s.is_sm = sm;
    s.mask = mask;
    s.a1 = 3'd6;
    s.u1 = 1'b1;
    return s;
  endfunction

  function automatic stim_t alu(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input logic u1, input logic u2, input logic rr_load,
                                input logic [AW-1:0] rd);
    stim_t s = '0;
    s.id_valid = 1'b1;
    s.a1 = a1;
    s.a2 = a2;
    s.u1 = u1;
    s.u2 = u2;
    s.rr_load = rr_load;
    s.rr_wr = 1'b1;
    s.rd = rd;
    return s;
  endfunction

  // Reference model: compute this cycle's outputs, then advance model state to the next edge.
  function automatic exp_t model(input stim_t s);
    exp_t e = '0;
    logic hz;
    logic [AW-1:0] low;
    hz = s.id_valid && s.rr_load && s.rr_wr &&
         ((s.u1 && s.a1 == s.rd) || (s.u2 && s.a2 == s.rd));
`ifdef LMSM_SEQ_EN
    e.busy = m_busy;
    if (m_busy) begin
      low = '0;
      for (int i = 0; i < NR; i++) begin
        if (m_mask[i]) begin
          low = i[AW-1:0];
          break;
        end
      end
      e.mv = 1'b1;
      e.addr = low;
      e.off = m_count;
      e.first = (m_count == 0);
      e.last = ($countones(m_mask) == 1);
      e.stall = !e.last;
      m_mask[low] = 1'b0;
      m_count = m_count + 1;
      if (e.last) m_busy = 1'b0;
    end else if (hz) begin
      e.stall = 1'b1;
      e.bubble = 1'b1;
    end else if (s.id_valid && (s.is_lm || s.is_sm)) begin
      e.bubble = 1'b1;
      e.stall = (s.mask != 0);
      if (!s.flush) begin
        m_mask = s.mask;
        m_count = '0;
        m_busy = (s.mask != 0);
      end
    end
`else
    if (hz) begin
      e.stall = 1'b1;
      e.bubble = 1'b1;
    end
`endif
    if (s.flush) begin
      e.stall = 1'b0; e.bubble = 1'b0; e.mv = 1'b0;
      e.addr = '0; e.off = '0; e.first = 1'b0; e.last = 1'b0;
      m_busy = 1'b0; m_mask = '0; m_count = '0;
    end
    if (s.rst) begin
      m_busy = 1'b0; m_mask = '0; m_count = '0;
    end
    return e;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    rst             = s.rst;
    id_valid        = s.id_valid;
    id_is_lm        = s.is_lm;
    id_is_sm        = s.is_sm;
    id_mask         = s.mask;
    id_rs1_addr     = s.a1;
    id_rs2_addr     = s.a2;
    id_uses_rs1     = s.u1;
    id_uses_rs2     = s.u2;
    rr_ex_is_load   = s.rr_load;
    rr_ex_rd_addr   = s.rd;
    rr_ex_reg_wr_en = s.rr_wr;
    flush_in        = s.flush;
    sb.push_back(model(s));
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput("stall_if_id",    32'(stall_if_id),    32'(e.stall));
      checkOutput("bubble_rr_ex",   32'(bubble_rr_ex),   32'(e.bubble));
      checkOutput("multi_valid",    32'(multi_valid),    32'(e.mv));
      checkOutput("multi_reg_addr", 32'(multi_reg_addr), 32'(e.addr));
      checkOutput("multi_offset",   32'(multi_offset),   32'(e.off));
      checkOutput("multi_first",    32'(multi_first),    32'(e.first));
      checkOutput("multi_last",     32'(multi_last),     32'(e.last));
      checkOutput("busy",           32'(busy),           32'(e.busy));
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    {id_valid, id_is_lm, id_is_sm, id_mask, id_rs1_addr, id_rs2_addr} = '0;
    {id_uses_rs1, id_uses_rs2, rr_ex_is_load, rr_ex_rd_addr, rr_ex_reg_wr_en, flush_in} = '0;

    // Reset
    s = idle(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idle());

    // Load R3 in RR/EX, ADD R1,R3,R2: one bubble, then the load has moved on
    applyStimulus(alu(3'd3, 3'd2, 1'b1, 1'b1, 1'b1, 3'd3));
    applyStimulus(alu(3'd3, 3'd2, 1'b1, 1'b1, 1'b0, 3'd0));
    // Match on rs2 only
    applyStimulus(alu(3'd1, 3'd5, 1'b1, 1'b1, 1'b1, 3'd5));
    // Address match but sources not used
    applyStimulus(alu(3'd3, 3'd3, 1'b0, 1'b0, 1'b1, 3'd3));
    // Load that does not write the register file
    s = alu(3'd4, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4); s.rr_wr = 1'b0;
    applyStimulus(s);
    // Hazard plus flush: flush suppresses the bubble
    s = alu(3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd2); s.flush = 1'b1;
    applyStimulus(s);
    applyStimulus(idle());

    // LM 1010_0101: R0,R2,R5,R7
    for (int i = 0; i < 5; i++) applyStimulus(multi(1'b0, 8'b1010_0101));
    applyStimulus(idle());

    // SM with empty mask
    applyStimulus(multi(1'b1, 8'h00));
    applyStimulus(idle());

    // LM 8'hFF with flush on the third micro-op
    applyStimulus(multi(1'b0, 8'hFF));
    applyStimulus(multi(1'b0, 8'hFF));
    applyStimulus(multi(1'b0, 8'hFF));
    s = multi(1'b0, 8'hFF); s.flush = 1'b1;
    applyStimulus(s);
    applyStimulus(idle());
    applyStimulus(idle());

    // Full mask to completion: offsets 0..7
    for (int i = 0; i < 9; i++) applyStimulus(multi(1'b0, 8'hFF));
    applyStimulus(idle());

    // Reset mid-LM 8'hF0, then LM 8'h01
    applyStimulus(multi(1'b0, 8'hF0));
    applyStimulus(multi(1'b0, 8'hF0));
    s = idle(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(idle());
    applyStimulus(multi(1'b0, 8'h01));
    applyStimulus(multi(1'b0, 8'h01));
    applyStimulus(idle());

    // Flush in the same cycle as a start: no sequence begins
    s = multi(1'b1, 8'h0C); s.flush = 1'b1;
    applyStimulus(s);
    applyStimulus(idle());

    // Load-use hazard takes priority over an LM start
    s = multi(1'b0, 8'h06); s.rr_load = 1'b1; s.rr_wr = 1'b1; s.rd = 3'd6;
    applyStimulus(s);
    applyStimulus(multi(1'b0, 8'h06));
    applyStimulus(multi(1'b0, 8'h06));
    applyStimulus(multi(1'b0, 8'h06));
    applyStimulus(idle());

    repeat (3) @(posedge clk);
    if (sb.size() != 0) checkOutput("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
